pci_bus_monitor: RTL and testbench

//  Passive consumer sitting downstream of the PCI master/target pair on the shared bus.

---
 rtl/pci_mon_pkg.sv | 31 +++
 rtl/pci_mon_fifo.sv | 73 +++++++
 rtl/pci_bus_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_pci_bus_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pci_mon_pkg.sv
// pci_mon_pkg
//   Shared definitions for the PCI bus monitor:
//   - PCI bus command encodings seen on C_BE_ during the address phase
//   - monitor FSM state encoding
//   - rec_t, the record pushed per completed data beat or master abort
package pci_mon_pkg;

    localparam logic [3:0] CMD_IO_RD  = 4'b0010;
    localparam logic [3:0] CMD_IO_WR  = 4'b0011;
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    localparam logic [3:0] CMD_CFG_RD = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_WAIT = 2'd1,
        ST_DATA      = 2'd2,
        ST_TURN      = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be_;
        logic        last;
        logic        abort;
    } rec_t;

endpackage

// File: rtl/pci_mon_fifo.sv
// pci_mon_fifo
//   DEPTH-entry synchronous FIFO of rec_t records with first-word-fall-through
//   head output. A push while full succeeds only when a pop happens in the
//   same cycle (the written slot is the one being vacated); otherwise the
//   push is ignored and the caller is expected to flag the drop.
// Ports
//   clk, reset_    clock, asynchronous active-low reset (clears contents)
//   push_i         write push_data_i this cycle
//   push_data_i    record to write
//   pop_i          consume the head record this cycle (ignored when empty)
//   head_o         current head record
//   full_o         count == DEPTH
//   empty_o        count == 0
//   count_o        number of stored records
module pci_mon_fifo
    import pci_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   push_i,
    input  rec_t                   push_data_i,
    input  logic                   pop_i,
    output rec_t                   head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pci_bus_monitor.sv
// pci_bus_monitor
//   Passive PCI bus monitor. Samples the bus every posedge, decodes address
//   and data phases, and queues one record per completed data beat (or one
//   per master abort) into a record FIFO drained through a valid/ready stream.
//   The monitor never drives the bus.
//
//   Stream handshake: a record transfers on a posedge where rec_valid and
//   rec_ready are both high; rec_* hold the head record while rec_valid is high
//   and rec_ready may be asserted at any time without depending on rec_valid.
//
// Ports
//   clk, reset_                       bus clock, asynchronous active-low reset
//   FRAME_, IRDY_, TRDY_, DEVSEL_     bus control, active low
//   C_BE_, AD                         command/byte enables and address/data
//   rec_valid / rec_ready             record stream handshake
//   rec_cmd, rec_addr, rec_data,
//   rec_be_, rec_last, rec_abort      head record fields
//   overflow                          sticky: a record was dropped on a full FIFO
//   txn_count, beat_count             only when PCI_MON_STATS_EN is defined
//   dbg_state_o                       current decoder state
//
// Configuration macro: PCI_MON_STATS_EN adds the txn_count/beat_count outputs.
module pci_bus_monitor
    import pci_mon_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ABORT_CLKS = 5
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        FRAME_,
    input  logic        IRDY_,
    input  logic        TRDY_,
    input  logic        DEVSEL_,
    input  logic [3:0]  C_BE_,
    input  logic [31:0] AD,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [3:0]  rec_cmd,
    output logic [31:0] rec_addr,
    output logic [31:0] rec_data,
    output logic [3:0]  rec_be_,
    output logic        rec_last,
    output logic        rec_abort,
    output logic        overflow,
`ifdef PCI_MON_STATS_EN
    output logic [15:0] txn_count,
    output logic [15:0] beat_count,
`endif
    output state_e      dbg_state_o
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int ACW = $clog2(ABORT_CLKS + 1);

    state_e         state_q, state_d;
    logic           frame_prev_q;
    logic [3:0]     cmd_q, cmd_d;
    logic [31:0]    addr_q, addr_d;
    logic [29:0]    idx_q, idx_d;
    logic [ACW-1:0] abort_cnt_q, abort_cnt_d;
    logic           overflow_q, overflow_d;

    logic           beat;
    logic           push;
    logic           txn_done;
    rec_t           push_rec;

    logic           pop;
    rec_t           head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    assign beat = !IRDY_ && !TRDY_ && !DEVSEL_;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        idx_d         = idx_q;
        abort_cnt_d   = abort_cnt_q;
        push          = 1'b0;
        txn_done      = 1'b0;
        push_rec.cmd   = cmd_q;
        push_rec.addr  = addr_q + {idx_q, 2'b00};
        push_rec.data  = AD;
        push_rec.be_   = C_BE_;
        push_rec.last  = FRAME_;
        push_rec.abort = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a falling FRAME_ starts a transaction.
                if (!FRAME_ && frame_prev_q) begin
                    addr_d      = AD & 32'hFFFF_FFFC;
                    cmd_d       = C_BE_;
                    idx_d       = '0;
                    abort_cnt_d = '0;
                    state_d     = ST_ADDR_WAIT;
                end
            end
            // ADDR_WAIT and DATA share beat handling: DEVSEL_ arriving in
            // ADDR_WAIT can complete a beat on the very same edge.
            ST_ADDR_WAIT, ST_DATA: begin
                if (beat) begin
                    push  = 1'b1;
                    idx_d = idx_q + 30'd1;
                    if (FRAME_) begin
                        state_d  = ST_TURN;
                        txn_done = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (FRAME_) begin
                    // FRAME_ released without a completing beat: protocol
                    // error, give up silently.
                    state_d = ST_IDLE;
                end else if (!DEVSEL_) begin
                    state_d = ST_DATA;
                end else if (state_q == ST_ADDR_WAIT) begin
                    if (abort_cnt_q == ACW'(ABORT_CLKS - 1)) begin
                        push           = 1'b1;
                        push_rec.addr  = addr_q;
                        push_rec.data  = '0;
                        push_rec.be_   = '0;
                        push_rec.last  = 1'b1;
                        push_rec.abort = 1'b1;
                        state_d        = ST_TURN;
                        txn_done       = 1'b1;
                    end else begin
                        abort_cnt_d = abort_cnt_q + 1'b1;
                    end
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop        = rec_ready && !fifo_empty;
    assign overflow_d = overflow_q || (push && fifo_full && !pop);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            frame_prev_q <= 1'b1;
            cmd_q        <= '0;
            addr_q       <= '0;
            idx_q        <= '0;
            abort_cnt_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= FRAME_;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            abort_cnt_q  <= abort_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    pci_mon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_      (reset_),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rec_valid   = (fifo_count != '0);
    assign rec_cmd     = head.cmd;
    assign rec_addr    = head.addr;
    assign rec_data    = head.data;
    assign rec_be_     = head.be_;
    assign rec_last    = head.last;
    assign rec_abort   = head.abort;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

`ifdef PCI_MON_STATS_EN
    logic [15:0] txn_count_q;
    logic [15:0] beat_count_q;

    // beat_count counts every push attempt, including ones dropped on overflow.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            txn_count_q  <= '0;
            beat_count_q <= '0;
        end else begin
            if (txn_done) txn_count_q  <= txn_count_q + 16'd1;
            if (push)     beat_count_q <= beat_count_q + 16'd1;
        end
    end

    assign txn_count  = txn_count_q;
    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_pci_bus_monitor.sv
// tb_pci_bus_monitor
//   Directed bench for pci_bus_monitor: drives bus cycles on the falling
//   edge, checks outputs on the falling edge, and drains records against a
//   queue of hand-computed expected records.
module tb_pci_bus_monitor;
    import pci_mon_pkg::*;

    localparam int DEPTH      = 8;
    localparam int ABORT_CLKS = 5;
    localparam int RW         = 74;

    logic        clk;
    logic        reset_;
    logic        FRAME_;
    logic        IRDY_;
    logic        TRDY_;
    logic        DEVSEL_;
    logic [3:0]  C_BE_;
    logic [31:0] AD;
    logic        rec_valid;
    logic        rec_ready;
    logic [3:0]  rec_cmd;
    logic [31:0] rec_addr;
    logic [31:0] rec_data;
    logic [3:0]  rec_be_;
    logic        rec_last;
    logic        rec_abort;
    logic        overflow;
    state_e      dbg_state;
`ifdef PCI_MON_STATS_EN
    logic [15:0] txn_count;
    logic [15:0] beat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];

    pci_bus_monitor #(
        .DEPTH      (DEPTH),
        .ABORT_CLKS (ABORT_CLKS)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .FRAME_      (FRAME_),
        .IRDY_       (IRDY_),
        .TRDY_       (TRDY_),
        .DEVSEL_     (DEVSEL_),
        .C_BE_       (C_BE_),
        .AD          (AD),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_cmd     (rec_cmd),
        .rec_addr    (rec_addr),
        .rec_data    (rec_data),
        .rec_be_     (rec_be_),
        .rec_last    (rec_last),
        .rec_abort   (rec_abort),
        .overflow    (overflow),
`ifdef PCI_MON_STATS_EN
        .txn_count   (txn_count),
        .beat_count  (beat_count),
`endif
        .dbg_state_o (dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Checking
    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_rec(input logic [3:0] cmd, input logic [31:0] addr,
                                             input logic [31:0] data, input logic [3:0] be,
                                             input logic last, input logic abort);
        return {cmd, addr, data, be, last, abort};
    endfunction

    // Drivers
    task automatic drive(input logic f, input logic i, input logic t, input logic d,
                         input logic [3:0] cbe, input logic [31:0] ad);
        FRAME_  = f;
        IRDY_   = i;
        TRDY_   = t;
        DEVSEL_ = d;
        C_BE_   = cbe;
        AD      = ad;
    endtask

    task automatic bus(input logic f, input logic i, input logic t, input logic d,
                       input logic [3:0] cbe, input logic [31:0] ad);
        @(negedge clk);
        drive(f, i, t, d, cbe, ad);
    endtask

    task automatic bus_idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0);
        end
    endtask

    // Scoreboard drain: every expected record must come out in order, then empty.
    task automatic drain(input string tag);
        int waited;
        logic [RW-1:0] exp;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (!rec_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!rec_valid) begin
                check({tag, "_timeout"}, 1'b0, 1'b1);
                exp_q.delete();
            end else begin
                exp = exp_q.pop_front();
                check(tag, {rec_cmd, rec_addr, rec_data, rec_be_, rec_last, rec_abort}, exp);
                rec_ready = 1'b1;
                @(negedge clk);
                rec_ready = 1'b0;
            end
        end
        check({tag, "_empty"}, rec_valid, 1'b0);
    endtask

    initial begin
        reset_    = 1'b0;
        rec_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0);

        // Reset state
        @(negedge clk);
        check("rst_valid", rec_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_ = 1'b1;
        bus_idle(4);
        check("idle_no_rec", rec_valid, 1'b0);
        check("idle_state", dbg_state, ST_IDLE);

        // MEM_WR, 3 beats at 0x1000
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_WR, 32'h0000_1000);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd1);
        @(negedge clk);
        check("wr_latency", rec_valid, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd2);
        bus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd3);
        bus_idle(1);
        check("wr_turn", dbg_state, ST_TURN);
        exp_q.push_back(mk_rec(4'b0111, 32'h0000_1000, 32'd1, 4'b0000, 1'b0, 1'b0));
        exp_q.push_back(mk_rec(4'b0111, 32'h0000_1004, 32'd2, 4'b0000, 1'b0, 1'b0));
        exp_q.push_back(mk_rec(4'b0111, 32'h0000_1008, 32'd3, 4'b0000, 1'b1, 1'b0));
        drain("wr_rec");

        // MEM_RD, single beat after 2 TRDY_ wait states at 0x40
        bus_idle(1);
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_RD, 32'h0000_0040);
        bus(1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h1111_1111);
        bus(1'b0, 1'b0, 1'b1, 1'b0, 4'b1100, 32'h2222_2222);
        bus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 32'hCAFE_F00D);
        bus_idle(2);
        exp_q.push_back(mk_rec(4'b0110, 32'h0000_0040, 32'hCAFE_F00D, 4'b1100, 1'b1, 1'b0));
        drain("rd_rec");

        // Master abort: DEVSEL_ never asserted after 0xDEADBEE0
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_RD, 32'hDEAD_BEE0);
        for (int k = 0; k < ABORT_CLKS - 1; k++) begin
            bus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h0);
        end
        bus(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h0);
        check("abort_not_early", rec_valid, 1'b0);
        bus_idle(1);
        check("abort_valid", rec_valid, 1'b1);
        check("abort_turn", dbg_state, ST_TURN);
        exp_q.push_back(mk_rec(4'b0110, 32'hDEAD_BEE0, 32'h0, 4'b0000, 1'b1, 1'b1));
        drain("abort_rec");

        // Overflow: DEPTH+2 beats with rec_ready low
        bus_idle(1);
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_WR, 32'h0000_2000);
        for (int k = 0; k < DEPTH + 2; k++) begin
            bus((k == DEPTH + 1), 1'b0, 1'b0, 1'b0, 4'b0000, 32'h100 + k);
            if (k == DEPTH) check("ovf_not_yet", overflow, 1'b0);
            if (k < DEPTH) exp_q.push_back(mk_rec(4'b0111, 32'h0000_2000 + 4 * k,
                                                  32'h100 + k, 4'b0000, 1'b0, 1'b0));
        end
        bus_idle(2);
        check("ovf_set", overflow, 1'b1);
        drain("ovf_rec");
        check("ovf_sticky", overflow, 1'b1);

        // Reset mid-burst after beat 2
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_WR, 32'h0000_3000);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'hAA);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'hBB);
        @(negedge clk);
        reset_ = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h0);
        #1;
        check("mid_rst_valid", rec_valid, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        reset_ = 1'b1;
        bus_idle(1);
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_RD, 32'h0000_4000);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h11);
        bus(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h22);
        // FRAME_ falls during the turnaround clock and stays low: not a new transaction
        bus(1'b0, 1'b1, 1'b1, 1'b1, CMD_MEM_WR, 32'h0000_5000);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h33);
        bus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h44);
        check("turn_ignored", dbg_state, ST_IDLE);
        bus_idle(1);
        exp_q.push_back(mk_rec(4'b0110, 32'h0000_4000, 32'h11, 4'b0000, 1'b0, 1'b0));
        exp_q.push_back(mk_rec(4'b0110, 32'h0000_4004, 32'h22, 4'b0000, 1'b1, 1'b0));
        drain("post_rst_rec");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
